lcd_ctrl_param: RTL and testbench
=================================

LCD_CTRL_PARAM -- requirements
Module: lcd_ctrl_param

Interface
REQ-001 Parameter: LOG_N, default 3, meaning image is N x N with N = 2**LOG_N (LOG_N >= 2).
REQ-002 Parameter: DW, default 8, meaning pixel width in bits.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  reset, asynchronous, active-high.
REQ-005 Port: cmd  input  4  command code, sampled only with cmd_valid.
REQ-006 Port: cmd_valid  input  1  command strobe.
REQ-007 Port: IROM_Q  input  DW  ROM read data, valid one cycle after IROM_A/IROM_rd.
REQ-008 Port: IROM_rd  output  1  ROM read enable.
REQ-009 Port: IROM_A  output  2*LOG_N  ROM address.
REQ-010 Port: IRAM_valid  output  1  RAM write strobe.
REQ-011 Port: IRAM_D  output  DW  RAM write data.
REQ-012 Port: IRAM_A  output  2*LOG_N  RAM write address.
REQ-013 Port: busy  output  1  high while not accepting commands.
REQ-014 Port: done  output  1  one-cycle pulse after write-out completes.

Function
REQ-015 Pixel (x,y) SHALL map to address y*N+x; origin is top-left; y increases downward.
REQ-016 The FSM SHALL have states LOAD, IDLE, EXEC, WRITE, DONE.
REQ-017 LOAD: IROM_rd=1 and IROM_A steps 0..N*N-1, one per cycle; IROM_Q is stored one cycle later; LOAD -> IDLE after the last pixel is stored.
REQ-018 IDLE: busy=0; cmd_valid=1 -> EXEC (cmd 1-15) or WRITE (cmd 0); cmd_valid is ignored in every other state.
REQ-019 The operation point (x,y) SHALL range 1..N-1 and initialise to (N/2,N/2) on entry to LOAD.
REQ-020 The window SHALL be P0=(x-1,y-1), P1=(x,y-1), P2=(x-1,y), P3=(x,y).
REQ-021 Shifts SHALL be 1=up (y-1), 2=down (y+1), 3=left (x-1), 4=right (x+1); a shift that would leave 1..N-1 leaves (x,y) unchanged.
REQ-022 Commands 5=MAX, 6=MIN, 7=AVG SHALL write the result to all four window pixels.
REQ-023 AVG SHALL be computed as a DW+2-bit sum of P0..P3 divided by 4 (see REQ-033).
REQ-024 Command 8=CCW SHALL apply P0<=P1, P1<=P3, P3<=P2, P2<=P0.
REQ-025 Command 9=CW SHALL apply P0<=P2, P1<=P0, P3<=P1, P2<=P3.
REQ-026 Command 10=mirror X SHALL swap P0<->P2 and P1<->P3; command 11=mirror Y SHALL swap P0<->P1 and P2<->P3.
REQ-027 Codes 12-15 SHALL be no-ops.
REQ-028 EXEC SHALL last exactly one cycle (busy=1) and then return to IDLE.
REQ-029 WRITE: IRAM_valid=1 with IRAM_A stepping 0..N*N-1 and IRAM_D = the stored pixel, one per cycle; then DONE.
REQ-030 DONE: done=1 and busy=1 for one cycle, then IDLE; further commands and writes are permitted, and the image and (x,y) are retained.

Reset
REQ-031 While reset is high: IROM_rd=0, IROM_A=0, IRAM_valid=0, IRAM_A=0, IRAM_D=0, done=0, busy=1, and the state is LOAD with the load counter at 0.
REQ-032 Reset asserted at any time SHALL abort the current operation with no done pulse; LOAD restarts from address 0 on the first cycle after deassertion.

Configuration
REQ-033 Macro LCD_CTRL_PARAM_ROUND_EN: when defined, AVG = (sum+2)>>2 (round half up); when undefined, AVG = sum>>2 (floor).

Verification
REQ-034 N=8, DW=8, ROM[a]=a -> load, then cmd 0 -> busy low after 64 loads; 64 IRAM_valid cycles with IRAM_D==IRAM_A; done high exactly 1 cycle.
REQ-035 Five cmd 1, then cmd 5, then cmd 0 -> y saturates at 1; addresses 3, 4, 11, 12 read 12; all others are unchanged.
REQ-036 From reset, cmd 7, then cmd 0 -> addresses 27, 28, 35, 36 read 31 (macro off) or 32 (macro on).
REQ-037 From reset, cmd 9, then cmd 0 -> addr27=35, addr28=27, addr36=28, addr35=36.
REQ-038 cmd_valid asserted during LOAD/WRITE with cmd 5 -> no effect on the image; reset at write cycle 20 -> IRAM_valid drops, no done, IROM_A restarts at 0.

Source files
------------

// File: rtl/lcd_ctrl_param.sv
// LCD image controller: loads an N x N image from IROM, edits a 2x2 window, and writes it out to IRAM.
// Defining LCD_CTRL_PARAM_ROUND_EN makes AVG round half up instead of truncating.
module lcd_ctrl_param #(
    parameter int LOG_N = 3,
    parameter int DW    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           cmd,
    input  logic                 cmd_valid,
    input  logic [DW-1:0]        IROM_Q,
    output logic                 IROM_rd,
    output logic [2*LOG_N-1:0]   IROM_A,
    output logic                 IRAM_valid,
    output logic [DW-1:0]        IRAM_D,
    output logic [2*LOG_N-1:0]   IRAM_A,
    output logic                 busy,
    output logic                 done
);

    localparam int N  = 2 ** LOG_N;
    localparam int NN = N * N;
    localparam int AW = 2 * LOG_N;
    localparam int CW = AW + 1;

    localparam logic [CW-1:0]    NN_C   = CW'(NN);
    localparam logic [AW-1:0]    LAST_A = AW'(NN - 1);
    localparam logic [LOG_N-1:0] C_ONE  = LOG_N'(1);
    localparam logic [LOG_N-1:0] C_MAX  = LOG_N'(N - 1);
    localparam logic [LOG_N-1:0] C_MID  = LOG_N'(N / 2);

    typedef enum logic [2:0] {LOAD, IDLE, EXEC, WRITE, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic              r_iromRd;
    logic [AW-1:0]     r_iromA;
    logic              r_rdD1;
    logic [AW-1:0]     r_aD1;
    logic [3:0]        r_cmd;
    logic [LOG_N-1:0]  r_x;
    logic [LOG_N-1:0]  r_y;
    logic [DW-1:0]     r_mem [NN];

    logic [LOG_N-1:0]  w_xm1;
    logic [LOG_N-1:0]  w_ym1;
    logic [AW-1:0]     w_a0;
    logic [AW-1:0]     w_a1;
    logic [AW-1:0]     w_a2;
    logic [AW-1:0]     w_a3;
    logic [DW-1:0]     w_p0;
    logic [DW-1:0]     w_p1;
    logic [DW-1:0]     w_p2;
    logic [DW-1:0]     w_p3;
    logic [DW-1:0]     w_max01;
    logic [DW-1:0]     w_max23;
    logic [DW-1:0]     w_max;
    logic [DW-1:0]     w_min01;
    logic [DW-1:0]     w_min23;
    logic [DW-1:0]     w_min;
    logic [DW+1:0]     w_sum;
    logic [DW-1:0]     w_avg;

    assign IROM_rd = r_iromRd;
    assign IROM_A  = r_iromA;

    // Window corners; N is a power of two so y*N+x is just {y,x}.
    assign w_xm1 = r_x - C_ONE;
    assign w_ym1 = r_y - C_ONE;
    assign w_a0  = {w_ym1, w_xm1};
    assign w_a1  = {w_ym1, r_x};
    assign w_a2  = {r_y, w_xm1};
    assign w_a3  = {r_y, r_x};
    assign w_p0  = r_mem[w_a0];
    assign w_p1  = r_mem[w_a1];
    assign w_p2  = r_mem[w_a2];
    assign w_p3  = r_mem[w_a3];

    assign w_max01 = (w_p0 > w_p1) ? w_p0 : w_p1;
    assign w_max23 = (w_p2 > w_p3) ? w_p2 : w_p3;
    assign w_max   = (w_max01 > w_max23) ? w_max01 : w_max23;
    assign w_min01 = (w_p0 < w_p1) ? w_p0 : w_p1;
    assign w_min23 = (w_p2 < w_p3) ? w_p2 : w_p3;
    assign w_min   = (w_min01 < w_min23) ? w_min01 : w_min23;
    assign w_sum   = {2'b00, w_p0} + {2'b00, w_p1} + {2'b00, w_p2} + {2'b00, w_p3};

`ifdef LCD_CTRL_PARAM_ROUND_EN
    assign w_avg = DW'((w_sum + (DW+2)'(2)) >> 2);
`else
    assign w_avg = DW'(w_sum >> 2);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            LOAD:    if (r_rdD1 && (r_aD1 == LAST_A)) w_next = IDLE;
            IDLE:    if (cmd_valid) w_next = (cmd == 4'd0) ? WRITE : EXEC;
            EXEC:    w_next = IDLE;
            WRITE:   if (r_cnt[AW-1:0] == LAST_A) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = LOAD;
        endcase
    end

    always_comb begin
        busy       = (r_state != IDLE);
        done       = (r_state == DONE);
        IRAM_valid = (r_state == WRITE);
        IRAM_A     = '0;
        IRAM_D     = '0;
        if (r_state == WRITE) begin
            IRAM_A = r_cnt[AW-1:0];
            IRAM_D = r_mem[r_cnt[AW-1:0]];
        end
    end

    // ROM reads are issued one per cycle; the address is delayed to line up with IROM_Q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_iromRd <= 1'b0;
            r_iromA  <= '0;
            r_rdD1   <= 1'b0;
            r_aD1    <= '0;
            r_cmd    <= '0;
            r_x      <= C_MID;
            r_y      <= C_MID;
        end else begin
            r_iromRd <= 1'b0;
            r_iromA  <= '0;
            r_rdD1   <= r_iromRd;
            r_aD1    <= r_iromA;
            case (r_state)
                LOAD: begin
                    if (r_cnt < NN_C) begin
                        r_iromRd <= 1'b1;
                        r_iromA  <= r_cnt[AW-1:0];
                        r_cnt    <= r_cnt + CW'(1);
                    end
                end
                IDLE: begin
                    if (cmd_valid) begin
                        r_cmd <= cmd;
                        r_cnt <= '0;
                    end
                end
                EXEC: begin
                    case (r_cmd)
                        4'd1:    if (r_y > C_ONE) r_y <= r_y - C_ONE;
                        4'd2:    if (r_y < C_MAX) r_y <= r_y + C_ONE;
                        4'd3:    if (r_x > C_ONE) r_x <= r_x - C_ONE;
                        4'd4:    if (r_x < C_MAX) r_x <= r_x + C_ONE;
                        default: ;
                    endcase
                end
                WRITE: r_cnt <= r_cnt + CW'(1);
                default: ;
            endcase
        end
    end

    // Image store is not reset; its contents are always rebuilt by LOAD.
    always_ff @(posedge clk) begin
        if ((r_state == LOAD) && r_rdD1) begin
            r_mem[r_aD1] <= IROM_Q;
        end else if (r_state == EXEC) begin
            case (r_cmd)
                4'd5, 4'd6, 4'd7: begin
                    r_mem[w_a0] <= (r_cmd == 4'd5) ? w_max : (r_cmd == 4'd6) ? w_min : w_avg;
                    r_mem[w_a1] <= (r_cmd == 4'd5) ? w_max : (r_cmd == 4'd6) ? w_min : w_avg;
                    r_mem[w_a2] <= (r_cmd == 4'd5) ? w_max : (r_cmd == 4'd6) ? w_min : w_avg;
                    r_mem[w_a3] <= (r_cmd == 4'd5) ? w_max : (r_cmd == 4'd6) ? w_min : w_avg;
                end
                4'd8: begin
                    r_mem[w_a0] <= w_p1;
                    r_mem[w_a1] <= w_p3;
                    r_mem[w_a3] <= w_p2;
                    r_mem[w_a2] <= w_p0;
                end
                4'd9: begin
                    r_mem[w_a0] <= w_p2;
                    r_mem[w_a1] <= w_p0;
                    r_mem[w_a3] <= w_p1;
                    r_mem[w_a2] <= w_p3;
                end
                4'd10: begin
                    r_mem[w_a0] <= w_p2;
                    r_mem[w_a2] <= w_p0;
                    r_mem[w_a1] <= w_p3;
                    r_mem[w_a3] <= w_p1;
                end
                4'd11: begin
                    r_mem[w_a0] <= w_p1;
                    r_mem[w_a1] <= w_p0;
                    r_mem[w_a2] <= w_p3;
                    r_mem[w_a3] <= w_p2;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Testbench for lcd_ctrl_param (N=8, DW=8, ROM[a]=a) using an image model and an IRAM scoreboard.
// Honours LCD_CTRL_PARAM_ROUND_EN for the expected AVG result.
module tb_lcd_ctrl_param;

    localparam int N  = 8;
    localparam int NN = 64;
`ifdef LCD_CTRL_PARAM_ROUND_EN
    localparam int AVG_EXP = 32;
`else
    localparam int AVG_EXP = 31;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] cmd = 4'd0;
    logic       cmd_valid = 1'b0;
    logic [7:0] IROM_Q = 8'd0;
    logic       IROM_rd;
    logic [5:0] IROM_A;
    logic       IRAM_valid;
    logic [7:0] IRAM_D;
    logic [5:0] IRAM_A;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [7:0] model [NN];
    logic [7:0] seen  [NN];
    int         mx;
    int         my;
    int         expA[$];
    int         expD[$];

    lcd_ctrl_param #(.LOG_N(3), .DW(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .IROM_Q     (IROM_Q),
        .IROM_rd    (IROM_rd),
        .IROM_A     (IROM_A),
        .IRAM_valid (IRAM_valid),
        .IRAM_D     (IRAM_D),
        .IRAM_A     (IRAM_A),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM holding its own address as data
    always @(posedge clk) begin
        if (IROM_rd) IROM_Q <= 8'(IROM_A);
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        for (int i = 0; i < NN; i++) model[i] = 8'(i);
        mx = N / 2;
        my = N / 2;
    endtask

    task automatic modelCmd(input int c);
        int a0, a1, a2, a3, s;
        logic [7:0] p0, p1, p2, p3, r;
        a0 = (my - 1) * N + mx - 1;
        a1 = (my - 1) * N + mx;
        a2 = my * N + mx - 1;
        a3 = my * N + mx;
        p0 = model[a0]; p1 = model[a1]; p2 = model[a2]; p3 = model[a3];
        s  = int'(p0) + int'(p1) + int'(p2) + int'(p3);
        r  = 8'd0;
        case (c)
            1: if (my > 1) my--;
            2: if (my < N - 1) my++;
            3: if (mx > 1) mx--;
            4: if (mx < N - 1) mx++;
            5, 6, 7: begin
                if (c == 5) begin
                    r = p0;
                    if (p1 > r) r = p1;
                    if (p2 > r) r = p2;
                    if (p3 > r) r = p3;
                end else if (c == 6) begin
                    r = p0;
                    if (p1 < r) r = p1;
                    if (p2 < r) r = p2;
                    if (p3 < r) r = p3;
                end else begin
`ifdef LCD_CTRL_PARAM_ROUND_EN
                    r = 8'((s + 2) / 4);
`else
                    r = 8'(s / 4);
`endif
                end
                model[a0] = r; model[a1] = r; model[a2] = r; model[a3] = r;
            end
            8:  begin model[a0] = p1; model[a1] = p3; model[a3] = p2; model[a2] = p0; end
            9:  begin model[a0] = p2; model[a1] = p0; model[a3] = p1; model[a2] = p3; end
            10: begin model[a0] = p2; model[a2] = p0; model[a1] = p3; model[a3] = p1; end
            11: begin model[a0] = p1; model[a1] = p0; model[a2] = p3; model[a3] = p2; end
            default: ;
        endcase
    endtask

    // Issue one non-write command from IDLE and confirm EXEC lasts one cycle
    task automatic applyStimulus(input int c);
        cmd = 4'(c);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        checkOutput("exec_busy", 32'(busy), 1);
        step();
        checkOutput("exec_back_idle", 32'(busy), 0);
        modelCmd(c);
    endtask

    task automatic doReset(input bit cmdDuringLoad);
        int nRd;
        bit sawDone;
        cmd_valid = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("rst_irom_rd", 32'(IROM_rd), 0);
        checkOutput("rst_irom_a", 32'(IROM_A), 0);
        checkOutput("rst_iram_valid", 32'(IRAM_valid), 0);
        checkOutput("rst_iram_a", 32'(IRAM_A), 0);
        checkOutput("rst_iram_d", 32'(IRAM_D), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_busy", 32'(busy), 1);
        step();
        step();
        reset = 1'b0;
        if (cmdDuringLoad) begin
            cmd = 4'd5;
            cmd_valid = 1'b1;
        end
        step();
        checkOutput("load_first_rd", 32'(IROM_rd), 1);
        checkOutput("load_first_a", 32'(IROM_A), 0);
        nRd = 0;
        sawDone = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (busy === 1'b0) break;
            if (done === 1'b1) sawDone = 1'b1;
            if (IROM_rd === 1'b1) begin
                checkOutput("load_addr", 32'(IROM_A), 32'(nRd));
                nRd++;
            end
            step();
        end
        cmd_valid = 1'b0;
        checkOutput("load_reads", 32'(nRd), 64);
        checkOutput("load_reaches_idle", 32'(busy), 0);
        checkOutput("load_no_done", 32'(sawDone), 0);
        modelReset();
    endtask

    task automatic runWrite(input bit holdCmd);
        int  nValid, ea, ed;
        bit  gotDone;
        for (int i = 0; i < NN; i++) begin
            expA.push_back(i);
            expD.push_back(int'(model[i]));
        end
        cmd = 4'd0;
        cmd_valid = 1'b1;
        step();
        if (holdCmd) cmd = 4'd5;
        else cmd_valid = 1'b0;
        nValid = 0;
        gotDone = 1'b0;
        for (int k = 0; k < 200 && !gotDone; k++) begin
            if (IRAM_valid === 1'b1) begin
                if (expA.size() == 0) begin
                    checkOutput("write_extra", 32'(IRAM_A), 32'hFFFF);
                end else begin
                    ea = expA.pop_front();
                    ed = expD.pop_front();
                    checkOutput("iram_a", 32'(IRAM_A), 32'(ea));
                    checkOutput("iram_d", 32'(IRAM_D), 32'(ed));
                end
                seen[IRAM_A] = IRAM_D;
                nValid++;
                step();
            end else if (done === 1'b1) begin
                gotDone = 1'b1;
            end else begin
                step();
            end
        end
        cmd_valid = 1'b0;
        checkOutput("write_count", 32'(nValid), 64);
        checkOutput("done_seen", 32'(gotDone), 1);
        checkOutput("scoreboard_empty", 32'(expA.size()), 0);
        if (gotDone) checkOutput("done_busy", 32'(busy), 1);
        expA.delete();
        expD.delete();
        step();
        checkOutput("done_one_cycle", 32'(done), 0);
        checkOutput("idle_after_done", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        #2;
        // Load with a MAX command held during LOAD and WRITE: image must stay the identity
        doReset(1'b1);
        runWrite(1'b1);
        checkOutput("id_addr0", 32'(seen[0]), 0);
        checkOutput("id_addr36", 32'(seen[36]), 36);
        checkOutput("id_addr63", 32'(seen[63]), 63);

        // Up saturation at y=1, then MAX
        for (int i = 0; i < 5; i++) applyStimulus(1);
        applyStimulus(5);
        runWrite(1'b0);
        checkOutput("max_addr3", 32'(seen[3]), 12);
        checkOutput("max_addr4", 32'(seen[4]), 12);
        checkOutput("max_addr11", 32'(seen[11]), 12);
        checkOutput("max_addr12", 32'(seen[12]), 12);
        checkOutput("max_addr19", 32'(seen[19]), 19);

        // Abort a write at cycle 20 with reset
        cmd = 4'd0;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        checkOutput("abort_pre_valid", 32'(IRAM_valid), 1);
        checkOutput("abort_pre_addr", 32'(IRAM_A), 20);
        doReset(1'b0);

        // AVG around the reset point
        applyStimulus(7);
        runWrite(1'b0);
        checkOutput("avg_addr27", 32'(seen[27]), 32'(AVG_EXP));
        checkOutput("avg_addr28", 32'(seen[28]), 32'(AVG_EXP));
        checkOutput("avg_addr35", 32'(seen[35]), 32'(AVG_EXP));
        checkOutput("avg_addr36", 32'(seen[36]), 32'(AVG_EXP));

        // Clockwise rotation
        doReset(1'b0);
        applyStimulus(9);
        runWrite(1'b0);
        checkOutput("cw_addr27", 32'(seen[27]), 35);
        checkOutput("cw_addr28", 32'(seen[28]), 27);
        checkOutput("cw_addr36", 32'(seen[36]), 28);
        checkOutput("cw_addr35", 32'(seen[35]), 36);

        // Mixed sequence: right/down saturation, CCW, mirrors, MIN, no-ops, AVG
        for (int i = 0; i < 4; i++) applyStimulus(4);
        applyStimulus(8);
        for (int i = 0; i < 4; i++) applyStimulus(2);
        applyStimulus(10);
        applyStimulus(3);
        applyStimulus(11);
        applyStimulus(6);
        applyStimulus(12);
        applyStimulus(15);
        applyStimulus(7);
        runWrite(1'b0);
        runWrite(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
